// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state type and array/feed defaults for the systolic feed controller.
package systolic_pkg;
  localparam int ARRAY_N = 4;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DRAIN_CYC = 2 * ARRAY_N;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// systolic_feed_ctrl_if: tile request and operand-feed signals; cycle_cnt exists only with FEED_CTRL_PERF_EN.
interface systolic_feed_ctrl_if import systolic_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);
  logic start;
  logic [15:0] k_len;
  logic [ADDR_W-1:0] a_base, b_base, a_addr, b_addr;
  logic rd_en, feed_valid, feed_zero, acc_clear, busy, done;
`ifdef FEED_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  modport master(output start, k_len, a_base, b_base,
                 input rd_en, a_addr, b_addr, feed_valid, feed_zero, acc_clear, busy, done, cycle_cnt);
  modport slave(input start, k_len, a_base, b_base,
                output rd_en, a_addr, b_addr, feed_valid, feed_zero, acc_clear, busy, done, cycle_cnt);
`else
  modport master(output start, k_len, a_base, b_base,
                 input rd_en, a_addr, b_addr, feed_valid, feed_zero, acc_clear, busy, done);
  modport slave(input start, k_len, a_base, b_base,
                output rd_en, a_addr, b_addr, feed_valid, feed_zero, acc_clear, busy, done);
`endif
endinterface

// File: rtl/step_counter.sv
// step_counter: loadable 16-bit down-counter with zero flag; stops at zero.
module step_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        dec_i,
  input  logic [15:0] val_i,
  output logic        zero_o
);
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != 16'd0) ? cnt_q - 16'd1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == 16'd0;
endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequences operand-buffer reads and drain cycles for one systolic tile.
// Optional FEED_CTRL_PERF_EN adds a saturating busy-cycle counter (cycle_cnt).
module systolic_feed_ctrl import systolic_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
  input logic clk,
  input logic rst,
  systolic_feed_ctrl_if.slave bus
);
  localparam logic [15:0] DRAIN_M1 = 16'(DRAIN_CYC - 1);
  state_t state_q, state_d;
  logic accept, cnt_zero, cnt_load, cnt_dec;
  logic [15:0] cnt_val;
  logic rd_en_q, rd_en_d, fv_q, fv_d, fz_q, fz_d, ac_q, ac_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  step_counter u_cnt (
    .clk(clk), .rst(rst), .load_i(cnt_load), .dec_i(cnt_dec), .val_i(cnt_val), .zero_o(cnt_zero)
  );
  // Counter holds steps remaining minus one: loaded with k_len-1 on accept, DRAIN_CYC-1 on entering DRAIN.
  always_comb begin
    accept = state_q == IDLE && bus.start;
    state_d = state_q;
    cnt_load = 1'b0;
    cnt_val = bus.k_len - 16'd1;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = bus.k_len == 16'd0 ? DONE : FEED;
        cnt_load = 1'b1;
      end
      FEED: if (cnt_zero) begin
        state_d = DRAIN_CYC == 0 ? DONE : DRAIN;
        cnt_load = 1'b1;
        cnt_val = DRAIN_M1;
      end
      DRAIN: if (cnt_zero) state_d = DONE;
      default: state_d = IDLE;
    endcase
    cnt_dec = state_q == FEED || state_q == DRAIN;
    rd_en_d = state_d == FEED;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    fv_d = rd_en_q;
    ac_d = rd_en_q & ~fv_q;
    fz_d = busy_d & ~fv_d;
    a_addr_d = accept ? bus.a_base : rd_en_q ? a_addr_q + ADDR_W'(1) : a_addr_q;
    b_addr_d = accept ? bus.b_base : rd_en_q ? b_addr_q + ADDR_W'(1) : b_addr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      {rd_en_q, fv_q, fz_q, ac_q, busy_q, done_q} <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
    end else begin
      state_q <= state_d;
      {rd_en_q, fv_q, fz_q, ac_q, busy_q, done_q} <= {rd_en_d, fv_d, fz_d, ac_d, busy_d, done_d};
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
    end
  assign bus.rd_en = rd_en_q;
  assign bus.a_addr = a_addr_q;
  assign bus.b_addr = b_addr_q;
  assign bus.feed_valid = fv_q;
  assign bus.feed_zero = fz_q;
  assign bus.acc_clear = ac_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef FEED_CTRL_PERF_EN
  logic [31:0] cyc_q, cyc_d;
  always_comb cyc_d = accept ? '0 : (busy_q && ~&cyc_q) ? cyc_q + 32'd1 : cyc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cyc_q <= '0;
    else cyc_q <= cyc_d;
  assign bus.cycle_cnt = cyc_q;
`endif
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: directed tiles with a queue scoreboard for reads, acc_clear and completion.
module tb_systolic_feed_ctrl;
  localparam int DRAIN = 8;
  typedef struct {int cyc; int nbusy; int nrd; int nfv; int nac;} tile_t;
  typedef struct {logic [15:0] a; logic [15:0] b;} addr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  addr_t rd_q[$];
  tile_t done_q[$];
  int ac_q[$];
  systolic_feed_ctrl_if #(.ADDR_W(16)) bus();
  systolic_feed_ctrl #(.ADDR_W(16), .DRAIN_CYC(DRAIN)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic unexpected(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s at cycle %0d: no expectation queued", name, cyc);
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Called 1ns after a rising edge; start is sampled at the next edge.
  task automatic issue(int k, logic [15:0] a, logic [15:0] b);
    int s;
    s = cyc;
    bus.start = 1'b1;
    bus.k_len = 16'(k);
    bus.a_base = a;
    bus.b_base = b;
    for (int i = 0; i < k; i++) rd_q.push_back(addr_t'{a: a + 16'(i), b: b + 16'(i)});
    if (k > 0) ac_q.push_back(s + 2);
    if (k > 0) done_q.push_back(tile_t'{cyc: s + k + DRAIN + 1, nbusy: k + DRAIN + 1, nrd: k, nfv: k, nac: 1});
    else done_q.push_back(tile_t'{cyc: s + 1, nbusy: 1, nrd: 0, nfv: 0, nac: 0});
    step(1);
    bus.start = 1'b0;
  endtask
  // Monitor: samples on the falling edge and pops expectations when the DUT presents them.
  initial begin
    int nbusy, nrd, nfv, nac, last_busy;
    logic prev_rd, prev_done;
    addr_t e;
    tile_t t;
    {nbusy, nrd, nfv, nac, last_busy} = '0;
    {prev_rd, prev_done} = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_outputs", {bus.rd_en, bus.feed_valid, bus.feed_zero, bus.acc_clear, bus.busy, bus.done, bus.a_addr, bus.b_addr}, 64'd0);
`ifdef FEED_CTRL_PERF_EN
        chk("reset_cycle_cnt", bus.cycle_cnt, 64'd0);
`endif
        {nbusy, nrd, nfv, nac} = '0;
        {prev_rd, prev_done} = '0;
      end else begin
        chk("feed_zero", bus.feed_zero, bus.busy & ~bus.feed_valid);
        chk("feed_valid_delay", bus.feed_valid, prev_rd);
        nbusy += int'(bus.busy);
        nrd += int'(bus.rd_en);
        nfv += int'(bus.feed_valid);
        nac += int'(bus.acc_clear);
        if (bus.rd_en) begin
          if (rd_q.size() == 0) unexpected("rd_en");
          else begin
            e = rd_q.pop_front();
            chk("a_addr", bus.a_addr, e.a);
            chk("b_addr", bus.b_addr, e.b);
          end
        end
        if (bus.acc_clear) begin
          if (ac_q.size() == 0) unexpected("acc_clear");
          else chk("acc_clear_cycle", cyc, ac_q.pop_front());
        end
        if (bus.done) begin
          if (done_q.size() == 0) unexpected("done");
          else begin
            t = done_q.pop_front();
            chk("done_cycle", cyc, t.cyc);
            chk("busy_cycles", nbusy, t.nbusy);
            chk("rd_count", nrd, t.nrd);
            chk("fv_count", nfv, t.nfv);
            chk("acc_clear_count", nac, t.nac);
            last_busy = t.nbusy;
          end
        end
`ifdef FEED_CTRL_PERF_EN
        if (prev_done) chk("cycle_cnt", bus.cycle_cnt, last_busy);
`endif
        if (!bus.busy) {nbusy, nrd, nfv, nac} = '0;
        prev_rd = bus.rd_en;
        prev_done = bus.done;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.a_base = '0;
    bus.b_base = '0;
    step(3);
    rst = 1'b0;
    issue(4, 16'h0010, 16'h0020);
    step(15);
`ifdef FEED_CTRL_PERF_EN
    chk("cycle_cnt_hold", bus.cycle_cnt, 64'd13);
`endif
    issue(0, 16'h1234, 16'h5678);
    step(4);
    issue(3, 16'hFFFE, 16'hFFFF);
    step(14);
    issue(1, 16'h0100, 16'h0200);
    step(12);
    // Start pulses in cycles 3 and 13 of the tile, with changed operands, must be ignored.
    issue(4, 16'h0040, 16'h0080);
    step(2);
    bus.start = 1'b1;
    bus.k_len = 16'd7;
    bus.a_base = 16'h0500;
    bus.b_base = 16'h0600;
    step(1);
    bus.start = 1'b0;
    step(9);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(15);
    issue(4, 16'h0300, 16'h0400);
    step(2);
    #1 rst = 1'b1;
    #1;
    chk("midrun_rst_rd_en", bus.rd_en, 64'd0);
    chk("midrun_rst_busy", bus.busy, 64'd0);
    chk("midrun_rst_fv", bus.feed_valid, 64'd0);
    chk("midrun_rst_fz", bus.feed_zero, 64'd0);
    chk("midrun_rst_addr", {bus.a_addr, bus.b_addr}, 64'd0);
    rd_q.delete();
    ac_q.delete();
    done_q.delete();
    step(1);
    rst = 1'b0;
    issue(2, 16'h0700, 16'h0800);
    step(14);
    chk("rd_q_empty", rd_q.size(), 64'd0);
    chk("ac_q_empty", ac_q.size(), 64'd0);
    chk("done_q_empty", done_q.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
